// File: rtl/step_pulse_monitor.sv
// Step-line receive monitor: synchronises the step input, rejects runt pulses,
// counts accepted pulses and measures rise-to-rise period and high width.
module step_pulse_monitor #(
  parameter int SIZE      = 16,
  parameter int CNT_W     = 32,
  parameter int MIN_WIDTH = 2,
  parameter int TIMEOUT   = 60000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             invert_pulse,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic [CNT_W-1:0] target_n,
  output logic [CNT_W-1:0] pulse_count,
  output logic [SIZE-1:0]  period,
  output logic [SIZE-1:0]  width,
  output logic             meas_valid,
  output logic             moving,
  output logic             glitch,
  output logic             timeout,
  output logic             done_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  localparam logic [SIZE-1:0] TIMEOUT_C = SIZE'(TIMEOUT);
  localparam logic [SIZE-1:0] MIN_W_C   = SIZE'(MIN_WIDTH);
  localparam logic [SIZE-1:0] ONE_C     = SIZE'(1);

  state_t           r_state, w_state_next;
  logic             r_s1, r_s2, r_p, r_p_d;
  logic             w_rise, w_fall, w_edge;
  logic [SIZE-1:0]  r_per_cnt, w_per_cnt_next, w_per_inc;
  logic [SIZE-1:0]  r_wid_cnt, w_wid_cnt_next, w_wid_inc;
  logic [SIZE-1:0]  r_width_lat, w_width_lat_next;
  logic [SIZE-1:0]  r_period, w_period_next;
  logic [SIZE-1:0]  r_width, w_width_next;
  logic             r_first, w_first_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             r_meas, w_meas_next;
  logic             r_moving, w_moving_next;
  logic             r_glitch, w_glitch_next;
  logic             r_timeout, w_timeout_next;
  logic             w_cnt_inc;
  logic             w_expired;

  // p is registered so every pin change reaches the FSM three edges after it is sampled
  assign w_rise    = r_p & ~r_p_d;
  assign w_fall    = ~r_p & r_p_d;
  assign w_edge    = w_rise | w_fall;
  assign w_expired = (r_per_cnt >= TIMEOUT_C);

  // Saturate so a pathological fall at the timeout count cannot wrap the counter
  assign w_per_inc = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + ONE_C;
  assign w_wid_inc = (r_wid_cnt == '1) ? r_wid_cnt : r_wid_cnt + ONE_C;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_p   <= 1'b0;
      r_p_d <= 1'b0;
    end else begin
      r_s1  <= pulse_in;
      r_s2  <= r_s1;
      r_p   <= r_s2 ^ invert_pulse;
      r_p_d <= r_p;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_per_cnt_next   = r_per_cnt;
    w_wid_cnt_next   = r_wid_cnt;
    w_width_lat_next = r_width_lat;
    w_period_next    = r_period;
    w_width_next     = r_width;
    w_first_next     = r_first;
    w_moving_next    = r_moving;
    w_meas_next      = 1'b0;
    w_glitch_next    = 1'b0;
    w_timeout_next   = 1'b0;
    w_cnt_inc        = 1'b0;

    if (!en) begin
      w_state_next  = S_IDLE;
      w_moving_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_ARM;

        S_ARM: begin
          if (w_rise) begin
            w_state_next   = S_HIGH;
            w_per_cnt_next = ONE_C;
            w_wid_cnt_next = ONE_C;
            w_first_next   = 1'b1;
          end
        end

        S_HIGH: begin
          w_per_cnt_next = w_per_inc;
          w_wid_cnt_next = w_wid_inc;
          if (w_fall) begin
            if (r_wid_cnt < MIN_W_C) begin
              w_glitch_next = 1'b1;
              w_moving_next = 1'b0;
              w_state_next  = S_ARM;
            end else begin
              // first clears here: once a full pulse is in, the next rise closes a period
              w_width_lat_next = r_wid_cnt;
              w_cnt_inc        = 1'b1;
              w_first_next     = 1'b0;
              w_state_next     = S_LOW;
            end
          end else if (w_expired && !w_edge) begin
            w_timeout_next = 1'b1;
            w_moving_next  = 1'b0;
            w_state_next   = S_ARM;
          end
        end

        S_LOW: begin
          w_per_cnt_next = w_per_inc;
          if (w_rise) begin
            if (!r_first) begin
              w_period_next = r_per_cnt;
              w_width_next  = r_width_lat;
              w_meas_next   = 1'b1;
              w_moving_next = 1'b1;
            end
            w_per_cnt_next = ONE_C;
            w_wid_cnt_next = ONE_C;
            w_first_next   = 1'b0;
            w_state_next   = S_HIGH;
          end else if (w_expired && !w_edge) begin
            w_timeout_next = 1'b1;
            w_moving_next  = 1'b0;
            w_state_next   = S_ARM;
          end
        end

        default: w_state_next = S_IDLE;
      endcase
    end

    // Clearing wins over an increment landing on the same edge
    if (clr_cnt) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + {{(CNT_W-1){1'b0}}, w_cnt_inc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_wid_cnt   <= '0;
      r_width_lat <= '0;
      r_period    <= '0;
      r_width     <= '0;
      r_first     <= 1'b0;
      r_count     <= '0;
      r_meas      <= 1'b0;
      r_moving    <= 1'b0;
      r_glitch    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_per_cnt   <= w_per_cnt_next;
      r_wid_cnt   <= w_wid_cnt_next;
      r_width_lat <= w_width_lat_next;
      r_period    <= w_period_next;
      r_width     <= w_width_next;
      r_first     <= w_first_next;
      r_count     <= w_count_next;
      r_meas      <= w_meas_next;
      r_moving    <= w_moving_next;
      r_glitch    <= w_glitch_next;
      r_timeout   <= w_timeout_next;
    end
  end

  assign pulse_count = r_count;
  assign period      = r_period;
  assign width       = r_width;
  assign meas_valid  = r_meas;
  assign moving      = r_moving;
  assign glitch      = r_glitch;
  assign timeout     = r_timeout;
  assign done_n      = (target_n != '0) && (r_count == target_n);

endmodule
